// File: rtl/mem_access_unit_if.sv
// Bus bundle for the data-memory access unit: pipeline request/response side plus
// the word-only memory port.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;

  // The unit itself drives the memory port and the response.
  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ReadData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output Address, WriteData, MemWrite, MemRead
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  Address, WriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory: sub-word loads with extension,
// sub-word stores by read-modify-write, alignment/range checking, one-cycle response.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 8192,
  parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFFC
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  state_t      state_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [15:0] wdata_q;
  logic [31:0] address_q;
  logic [31:0] writeData_q;
  logic        memWrite_q;
  logic        memRead_q;
  logic        reqReady_q;
  logic        respValid_q;
  logic [31:0] respRdata_q;
  logic        respErr_q;

  logic [31:0] wordIdx;
  logic        reqErr;
  logic        reqWordStore;

  assign wordIdx      = {2'b00, bus.req_addr[31:2]};
  assign reqWordStore = bus.req_write && (bus.req_size == SIZE_WORD);

  always_comb begin
    reqErr = 1'b0;
    if (bus.req_size == SIZE_BAD)                                   reqErr = 1'b1;
    if ((bus.req_size == SIZE_HALF) && bus.req_addr[0])             reqErr = 1'b1;
    if ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00)) reqErr = 1'b1;
    if (wordIdx >= MEM_WORDS)                                       reqErr = 1'b1;
  end

  function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      SIZE_HALF: res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default:   res = word;
    endcase
    return res;
  endfunction

  // Only the addressed lane is replaced; every other bit of the old word survives.
  function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic [15:0] wdata);
    logic [31:0] res;
    res = word;
    if (size == SIZE_BYTE) begin
      case (lane)
        2'd0:    res[7:0]   = wdata[7:0];
        2'd1:    res[15:8]  = wdata[7:0];
        2'd2:    res[23:16] = wdata[7:0];
        default: res[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      res[31:16] = wdata;
    end else begin
      res[15:0] = wdata;
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= 16'h0;
      address_q   <= PARK_ADDR;
      writeData_q <= 32'h0;
      memWrite_q  <= 1'b0;
      memRead_q   <= 1'b0;
      reqReady_q  <= 1'b1;
      respValid_q <= 1'b0;
      respRdata_q <= 32'h0;
      respErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            lane_q     <= bus.req_addr[1:0];
            size_q     <= bus.req_size;
            signed_q   <= bus.req_signed;
            write_q    <= bus.req_write;
            wdata_q    <= bus.req_wdata[15:0];
            reqReady_q <= 1'b0;
            if (reqErr) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respErr_q   <= 1'b1;
              respRdata_q <= 32'h0;
            end else if (reqWordStore) begin
              state_q     <= WR;
              address_q   <= {bus.req_addr[31:2], 2'b00};
              writeData_q <= bus.req_wdata;
              memWrite_q  <= 1'b1;
            end else begin
              state_q   <= RD;
              address_q <= {bus.req_addr[31:2], 2'b00};
              memRead_q <= 1'b1;
            end
          end
        end
        RD: begin
          memRead_q <= 1'b0;
          if (write_q) begin
            state_q     <= WR;
            memWrite_q  <= 1'b1;
            writeData_q <= mergeStore(bus.ReadData, lane_q, size_q, wdata_q);
          end else begin
            state_q     <= RESP;
            address_q   <= PARK_ADDR;
            respValid_q <= 1'b1;
            respErr_q   <= 1'b0;
            respRdata_q <= extendLoad(bus.ReadData, lane_q, size_q, signed_q);
          end
        end
        WR: begin
          state_q     <= RESP;
          memWrite_q  <= 1'b0;
          address_q   <= PARK_ADDR;
          respValid_q <= 1'b1;
          respErr_q   <= 1'b0;
          respRdata_q <= 32'h0;
        end
        default: begin
          state_q     <= IDLE;
          respValid_q <= 1'b0;
          respErr_q   <= 1'b0;
          respRdata_q <= 32'h0;
          reqReady_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = reqReady_q;
  assign bus.resp_valid = respValid_q;
  assign bus.resp_rdata = respRdata_q;
  assign bus.resp_err   = respErr_q;
  assign bus.Address    = address_q;
  assign bus.WriteData  = writeData_q;
  assign bus.MemWrite   = memWrite_q;
  assign bus.MemRead    = memRead_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a word-wide memory model
// and hand-written sequences for reset and abort behaviour.
module tb_mem_access_unit;
  localparam int unsigned MEM_WORDS = 8192;
  localparam logic [31:0] PARK      = 32'hFFFF_FFFC;

  typedef struct {
    string       name;
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    logic [31:0] expWdata;
  } TestVector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .PARK_ADDR(PARK)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [31:0] mem [MEM_WORDS];
  logic        loadEn = 1'b0;
  logic [12:0] loadIdx = 13'h0;
  logic [31:0] loadData = 32'h0;

  // Memory model: commits on the rising edge, reads combinationally while MemRead is high.
  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.Address[14:2]] <= bus.WriteData;
    else if (loadEn)  mem[loadIdx] <= loadData;
  end
  assign bus.ReadData = bus.MemRead ? mem[bus.Address[14:2]] : 32'hBAD0_BAD0;

  int checks = 0;
  int errors = 0;
  TestVector vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    loadEn = 1'b1;
    loadIdx = idx[12:0];
    loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic applyStimulus(input TestVector v, output int lat, output int rdCnt, output int wrCnt,
                               output logic [31:0] rdata, output logic err, output logic [31:0] lastWd,
                               output logic readyAtReq, output logic [31:0] addrAtResp);
    lat = 0; rdCnt = 0; wrCnt = 0; rdata = 32'h0; err = 1'b0; lastWd = 32'h0; addrAtResp = 32'h0;
    @(negedge clk);
    readyAtReq = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_size = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.MemRead) rdCnt++;
      if (bus.MemWrite) begin
        wrCnt++;
        lastWd = bus.WriteData;
      end
      if (bus.resp_valid) begin
        lat = c;
        rdata = bus.resp_rdata;
        err = bus.resp_err;
        addrAtResp = bus.Address;
        break;
      end
    end
  endtask

  task automatic runVector(input TestVector v);
    int lat, rdCnt, wrCnt;
    logic [31:0] rdata, lastWd, addrAtResp;
    logic err, readyAtReq;
    int expRd, expWr;
    applyStimulus(v, lat, rdCnt, wrCnt, rdata, err, lastWd, readyAtReq, addrAtResp);
    expRd = (v.expErr || (v.write && v.size == 2'b10)) ? 0 : 1;
    expWr = (!v.expErr && v.write) ? 1 : 0;
    checkOutput({v.name, "_ready"}, {31'h0, readyAtReq}, 32'h1);
    checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({v.name, "_rdata"}, rdata, v.expRdata);
    checkOutput({v.name, "_err"}, {31'h0, err}, {31'h0, v.expErr});
    checkOutput({v.name, "_memread_cycles"}, 32'(rdCnt), 32'(expRd));
    checkOutput({v.name, "_memwrite_cycles"}, 32'(wrCnt), 32'(expWr));
    checkOutput({v.name, "_parked"}, addrAtResp, PARK);
    if (expWr == 1) checkOutput({v.name, "_writedata"}, lastWd, v.expWdata);
  endtask

  initial begin
    int respSeen;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;

    // Preload while the unit is held in reset.
    preload(0, 32'h0000_8000);
    preload(2, 32'hAAAA_BBBB);
    preload(4, 32'h1234_5678);
    preload(8191, 32'h8100_0000);

    #1;
    checkOutput("reset_ready", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("reset_address", bus.Address, PARK);
    checkOutput("reset_writedata", bus.WriteData, 32'h0);
    checkOutput("reset_memwrite", {31'h0, bus.MemWrite}, 32'h0);
    checkOutput("reset_memread", {31'h0, bus.MemRead}, 32'h0);
    checkOutput("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    checkOutput("reset_resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset_resp_err", {31'h0, bus.resp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //             name         wr    size   sgn   addr           wdata          expRdata       err   lat expWdata
    vecs.push_back('{"lw_10",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 2, 32'h0});
    vecs.push_back('{"lb_1",     1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 32'h0});
    vecs.push_back('{"lbu_1",    1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,         32'h0000_0080, 1'b0, 2, 32'h0});
    vecs.push_back('{"sh_a",     1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_1234, 32'h0,         1'b0, 3, 32'h1234_BBBB});
    vecs.push_back('{"lw_8",     1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_BBBB, 1'b0, 2, 32'h0});
    vecs.push_back('{"lw_6_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1, 1, 32'h0});
    vecs.push_back('{"lw_range", 1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0,         32'h0,         1'b1, 1, 32'h0});
    vecs.push_back('{"size_11",  1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1, 32'h0});
    vecs.push_back('{"sh_5_mis", 1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_FFFF, 32'h0,         1'b1, 1, 32'h0});
    vecs.push_back('{"sw_20",    1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 32'hDEAD_BEEF});
    vecs.push_back('{"lw_20",    1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 32'h0});
    vecs.push_back('{"lh_a",     1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0,         32'h0000_1234, 1'b0, 2, 32'h0});
    vecs.push_back('{"lh_8",     1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0,         32'hFFFF_BBBB, 1'b0, 2, 32'h0});
    vecs.push_back('{"lhu_8",    1'b0, 2'b01, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_BBBB, 1'b0, 2, 32'h0});
    vecs.push_back('{"sb_3",     1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'hFFFF_FF5A, 32'h0,         1'b0, 3, 32'h5A00_8000});
    vecs.push_back('{"lw_0",     1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'h5A00_8000, 1'b0, 2, 32'h0});
    vecs.push_back('{"lbu_3",    1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,         32'h0000_005A, 1'b0, 2, 32'h0});
    vecs.push_back('{"lb_last",  1'b0, 2'b00, 1'b1, 32'h0000_7FFF, 32'h0,         32'hFFFF_FF81, 1'b0, 2, 32'h0});
    vecs.push_back('{"lw_sgn",   1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 2, 32'h0});

    foreach (vecs[i]) runVector(vecs[i]);

    // Abort a sub-word store during its write cycle; memory must keep the old word.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h0000_0003;
    bus.req_wdata = 32'h0000_0011;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("abort_rd_memread", {31'h0, bus.MemRead}, 32'h1);
    @(negedge clk);
    checkOutput("abort_wr_memwrite", {31'h0, bus.MemWrite}, 32'h1);
    checkOutput("abort_wr_writedata", bus.WriteData, 32'h1100_8000);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_memwrite_dropped", {31'h0, bus.MemWrite}, 32'h0);
    checkOutput("abort_address", bus.Address, PARK);
    checkOutput("abort_writedata", bus.WriteData, 32'h0);
    checkOutput("abort_memread", {31'h0, bus.MemRead}, 32'h0);
    checkOutput("abort_ready", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("abort_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    respSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) respSeen++;
    end
    checkOutput("abort_no_response", 32'(respSeen), 32'h0);
    checkOutput("abort_mem_unchanged", mem[0], 32'h5A00_8000);

    runVector('{"lw_after_abort", 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h5A00_8000, 1'b0, 2, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface; sits between the pipeline's MEM stage and the word-only data memory.
- Accepts one load or store request at a time and drives Address, WriteData, MemWrite and MemRead.
- Implements byte and halfword loads (signed and unsigned) and byte and halfword stores. Sub-word stores use read-modify-write.
- Checks alignment and range, and returns a single-cycle response to the pipeline.

Parameters:
- MEM_WORDS, 8192, number of 32-bit words in the data memory. A word index of MEM_WORDS or more is out of range.
- PARK_ADDR, 32'hFFFF_FFFC, value driven on Address whenever no read or write cycle is active.

Ports:
- clk  in  1  clock; memory writes and all state updates occur on its rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal and raises an error
- req_signed  in  1  sign-extend loads; ignored for stores and word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal size; valid with resp_valid
- Address  out  32  memory byte address
- WriteData  out  32  memory write word
- MemWrite  out  1  memory write strobe
- MemRead  out  1  memory read enable
- ReadData  in  32  memory read word; updates combinationally when Address changes while MemRead=1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE, Address=PARK_ADDR, WriteData=0, MemWrite=0, MemRead=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Reset mid-operation: takes effect immediately, drops MemWrite, and aborts any in-flight request with no response.
- Registered outputs: all outputs are registered. req_ready=(state==IDLE).
- Accept rule: a request is accepted on a rising edge with req_valid && req_ready. At accept, addr, size, signed, write and wdata are captured.
- Error check at accept. An error is raised if any of these hold:
  - size==11;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0;
  - (addr>>2) >= MEM_WORDS.
- States: IDLE, RD, WR, RESP.
- Error path: IDLE goes directly to RESP with resp_err=1, resp_rdata=0, and no memory access.
- Load path: IDLE -> RD -> RESP.
- Word store path: IDLE -> WR -> RESP.
- Sub-word store path: IDLE -> RD -> WR -> RESP.
- RD state: Address={addr[31:2],2'b00}, MemRead=1, MemWrite=0. ReadData is sampled at the edge that ends RD.
- WR state: Address={addr[31:2],2'b00}, MemWrite=1, MemRead=0, WriteData=merged word. The memory commits on the edge that ends WR.
- RESP state: resp_valid=1 for exactly one cycle. Next state is IDLE.
- Parking: in IDLE and RESP, Address=PARK_ADDR, MemRead=0 and MemWrite=0. Every RD cycle therefore changes Address, which forces a fresh ReadData even for repeated accesses to the same word or a read right after a write.
- Latency, counted from the accept edge:
  - resp_valid is high in cycle 2 for loads and word stores;
  - cycle 3 for sub-word stores;
  - cycle 1 for errors.
  - Throughput is one request per latency+1 cycles.
- Byte lanes (little-endian): byte k=addr[1:0] occupies bits [8k+7:8k]; half k=addr[1] occupies bits [16k+15:16k].
- Load extension: zero- or sign-extend the selected lane to 32 bits, using req_signed as captured.
- Merge for sub-word stores: the RD word with the selected lane replaced by req_wdata[7:0] or req_wdata[15:0]; all other bits are unchanged.
- No back-pressure on the response: resp_valid is not stalled. req_valid asserted outside IDLE is ignored and not queued.

Test Plan:
- Word load: mem[4]=32'h1234_5678; load word at addr 0x10 -> resp_valid in cycle 2, resp_rdata=32'h1234_5678, resp_err=0; MemRead high only during the RD cycle.
- Signed vs unsigned byte load: mem[0]=32'h0000_8000; lb at addr 0x1 -> 32'hFFFF_FF80; lbu at addr 0x1 -> 32'h0000_0080.
- Halfword store RMW: mem[2]=32'hAAAA_BBBB; sh at addr 0xA with wdata 32'h0000_1234:
  - RD then WR cycles with WriteData=32'h1234_BBBB;
  - resp_valid in cycle 3;
  - a following lw at 0x8 returns 32'h1234_BBBB.
- Error cases:
  - lw at addr 0x6 -> resp_valid in cycle 1, resp_err=1, resp_rdata=0, no MemRead or MemWrite pulse;
  - addr 0x8000 with MEM_WORDS=8192 -> resp_err=1;
  - size=11 -> resp_err=1.
- Reset mid-RMW: assert rst_n=0 during the WR cycle of sb at 0x3 -> MemWrite drops asynchronously, all outputs return to reset values, and no resp_valid is produced.
- Write-then-read same word: sw 32'hDEAD_BEEF at 0x20, then immediately lw at 0x20 -> resp_rdata=32'hDEAD_BEEF, because Address parks to 32'hFFFF_FFFC between the two accesses.
